video_text_writer: RTL and testbench
====================================

Name: video_text_writer

Overview:
- Formats a 16-bit value as ASCII text and writes it, one character per clock, into the 64x64-cell character video memory at a given row/column.
- Sits upstream of video_memory on its write port, which it drives.
- Replaces hand-coded write sequencers so that live values (mic sample, osc state, counters) can be printed on the SVGA text layer.
- Supports hex, unsigned decimal and single-character output.

Parameters:
- COL_BITS, 6, column address bits; the row is also 6 bits, so w_addr is 12 bits.
- BLANK_LEADING, 1, 1 = decimal leading zeros are written as SPACE_CHAR (never the last digit); 0 = zeros are kept.
- SPACE_CHAR, 8'h20, blank character code.

Ports:
- clk  in  1  system clock
- reset_p  in  1  asynchronous, active-high reset
- video_reset_done  in  1  video memory initialisation complete; writes are allowed only while high
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept a request
- req_mode  in  2  0 = 4 hex digits, 1 = 5 decimal digits, 2 = single char req_value[7:0], 3 = treated as 0
- req_row  in  6  character row
- req_col  in  6  starting character column
- req_value  in  16  value to print
- w_addr  out  12  {row, col} write address to video memory
- w_data  out  8  ASCII character
- w_valid  out  1  write strobe; one character per cycle
- done  out  1  one-cycle pulse after the last character of a request is written
- busy  out  1  equals ~req_ready

Behaviour:
- Reset (async, reset_p=1): state IDLE; w_valid=0, w_addr=0, w_data=0, done=0, req_ready=0 until reset is released and video_reset_done=1. All internal registers are cleared.
- req_ready = (state==IDLE) & video_reset_done, decoded combinationally from registers.
- Handshake: a request is accepted on the rising edge where req_valid & req_ready. mode, row, col and value are latched at acceptance; later changes to the req_* inputs are ignored.
- States:
  - IDLE -> WRITE on acceptance for modes 0, 2, 3.
  - IDLE -> CONVERT for mode 1.
  - CONVERT: iterative double-dabble, one shift per cycle, exactly 16 cycles. Produces 5 BCD digits (max 65535). Then -> WRITE.
  - WRITE: emits N characters on consecutive cycles (N = 4 hex, 5 dec, 1 char). The last character goes to DONE.
  - DONE: done=1 for one cycle, w_valid=0. -> IDLE.
- Outputs are registered. w_valid is high for exactly N consecutive cycles and low otherwise.
- Latency, with acceptance edge = cycle 0:
  - Hex: writes in cycles 1..4, done in cycle 5, req_ready high again in cycle 6.
  - Decimal: convert in cycles 1..16, writes in 17..21, done in 22, ready in 23.
  - Char: write in cycle 1, done in 2, ready in 3.
- Character order: most significant digit first, at column req_col. Character i goes to address {row, (col+i) mod 64}. The column wraps within the same row; the row never increments.
- Hex ASCII: digit 0..9 -> 8'h30+d; digit 10..15 -> 8'h41+(d-10), uppercase.
- Decimal ASCII: 8'h30+d. With BLANK_LEADING=1, zeros before the first nonzero digit become SPACE_CHAR; the units digit is always printed.
- video_reset_done falling during CONVERT/WRITE/DONE:
  - Abort: state -> IDLE next edge; w_valid=0 from that edge; no done pulse; the request is lost.
  - req_ready stays low until video_reset_done returns high.
- reset_p asserted mid-operation: outputs go to reset values immediately (async); no further writes.
- req_valid held high with a new request: the next request is accepted no earlier than the first cycle req_ready=1 after DONE; there are no back-to-back writes between requests.

Test Plan:
- Hex: row=16, col=2, mode 0, value 16'hBEEF -> writes (0x402,'B'=42), (0x403,'E'=45), (0x404,'E'), (0x405,'F'=46) in cycles 1..4; done in cycle 5; ready in cycle 6.
- Decimal: mode 1, value 16'd1234, row 0, col 0, BLANK_LEADING=1 -> w_valid low cycles 1..16; writes 20,31,32,33,34 to addresses 0x000..0x004 in cycles 17..21; done in cycle 22. Repeat with value 0 -> 20,20,20,20,30. Repeat with 65535 -> 36,35,35,33,35.
- Column wrap: row 1, col 62, mode 0, value 16'h0A5F -> addresses 0x07E, 0x07F, 0x040, 0x041; data 30,41,35,46.
- Char mode and mode 3: mode 2, value 16'h1248, row 63, col 63 -> single write (0xFFF, 8'h48), done in cycle 2. Mode 3, value 16'h00FF -> identical to hex '0','0','F','F'.
- Gating and abort: hold video_reset_done=0 with req_valid=1 -> req_ready=0, no writes. Raise it -> accept. Drop it in cycle 2 of a hex write -> w_valid=0 from the next edge, no done, req_ready=0 until it returns.
- Async reset: assert reset_p mid-cycle during WRITE -> w_valid, done, w_addr, w_data go to 0 before the next clk edge. After release, a new request behaves normally with no residue of the previous value.

Source files
------------

// File: rtl/video_text_writer.sv
// Prints a 16-bit value as hex, decimal or a single character into the 64x64 text video memory,
// one character per clock, and drives the memory write port.
module video_text_writer #(
  parameter int unsigned COL_BITS      = 6,
  parameter bit          BLANK_LEADING = 1'b1,
  parameter logic [7:0]  SPACE_CHAR    = 8'h20
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic                  video_reset_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_mode,
  input  logic [5:0]            req_row,
  input  logic [COL_BITS-1:0]   req_col,
  input  logic [15:0]           req_value,
  output logic [COL_BITS+5:0]   w_addr,
  output logic [7:0]            w_data,
  output logic                  w_valid,
  output logic                  done,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StConvert, StWrite, StDone} state_e;

  localparam logic [1:0] ModeHex  = 2'd0;
  localparam logic [1:0] ModeDec  = 2'd1;
  localparam logic [1:0] ModeChar = 2'd2;

  state_e              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [5:0]          row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [2:0]          idx_q, idx_d;
  logic [3:0]          cnt_q, cnt_d;
  // {digits[19:0], binary[15:0]}; digits hold 5 BCD digits or {4'h0, hex value}
  logic [35:0]         conv_q, conv_d;
  logic [COL_BITS+5:0] w_addr_q, w_addr_d;
  logic [7:0]          w_data_q, w_data_d;
  logic                w_valid_q, w_valid_d;
  logic                done_q, done_d;

  function automatic logic [35:0] dd_step(input logic [35:0] sr);
    logic [35:0] t;
    t = sr;
    for (int k = 0; k < 5; k++) begin
      if (t[16+4*k +: 4] >= 4'd5) t[16+4*k +: 4] = t[16+4*k +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  function automatic logic [7:0] char_of(input logic [1:0] m, input logic [19:0] dg,
                                         input logic [2:0] i);
    logic [2:0] pos;
    logic [3:0] nib;
    logic       lead;
    pos = (m == ModeDec) ? i : i + 3'd1;
    case (pos)
      3'd0:    nib = dg[19:16];
      3'd1:    nib = dg[15:12];
      3'd2:    nib = dg[11:8];
      3'd3:    nib = dg[7:4];
      default: nib = dg[3:0];
    endcase
    if (m == ModeChar) return dg[7:0];
    if (m == ModeHex) return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    // Leading blank: every digit up to and including this one is zero
    lead = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) <= i && dg[19-4*k -: 4] != 4'd0) lead = 1'b0;
    end
    if (BLANK_LEADING && i != 3'd4 && lead) return SPACE_CHAR;
    return 8'h30 + {4'h0, nib};
  endfunction

  assign req_ready = (state_q == StIdle) & video_reset_done & ~reset_p;
  assign busy      = ~req_ready;
  assign w_addr    = w_addr_q;
  assign w_data    = w_data_q;
  assign w_valid   = w_valid_q;
  assign done      = done_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    row_d     = row_q;
    col_d     = col_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    conv_d    = conv_q;
    w_addr_d  = '0;
    w_data_d  = '0;
    w_valid_d = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          mode_d = (req_mode == 2'd3) ? ModeHex : req_mode;
          row_d  = req_row;
          col_d  = req_col;
          idx_d  = '0;
          cnt_d  = '0;
          if (req_mode == ModeDec) begin
            conv_d  = {20'h0, req_value};
            state_d = StConvert;
          end else begin
            conv_d  = {4'h0, req_value, 16'h0};
            state_d = StWrite;
          end
        end
      end
      StConvert: begin
        conv_d = dd_step(conv_q);
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = StWrite;
      end
      StWrite: begin
        if ((mode_q == ModeDec  && idx_q == 3'd4) ||
            (mode_q == ModeChar && idx_q == 3'd0) ||
            (mode_q == ModeHex  && idx_q == 3'd3)) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && !video_reset_done) state_d = StIdle;

    // Outputs are registered alongside the state they belong to
    if (state_d == StWrite) begin
      w_valid_d = 1'b1;
      w_addr_d  = {row_d, col_d + COL_BITS'(idx_d)};
      w_data_d  = char_of(mode_d, conv_d[35:16], idx_d);
    end
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q   <= StIdle;
      mode_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      conv_q    <= '0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      row_q     <= row_d;
      col_q     <= col_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      conv_q    <= conv_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      w_valid_q <= w_valid_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_video_text_writer.sv
// Self-checking bench for video_text_writer: directed and random requests compared against a
// cycle-level expectation derived from plain arithmetic on the requested value.
module tb_video_text_writer;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        video_reset_done;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_mode;
  logic [5:0]  req_row;
  logic [5:0]  req_col;
  logic [15:0] req_value;
  logic [11:0] w_addr;
  logic [7:0]  w_data;
  logic        w_valid;
  logic        done;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  video_text_writer dut (
    .clk              (clk),
    .reset_p          (reset_p),
    .video_reset_done (video_reset_done),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_mode         (req_mode),
    .req_row          (req_row),
    .req_col          (req_col),
    .req_value        (req_value),
    .w_addr           (w_addr),
    .w_data           (w_data),
    .w_valid          (w_valid),
    .done             (done),
    .busy             (busy)
  );

  // Expected ASCII for character i of a request
  function automatic logic [7:0] exp_char(input int mode, input int value, input int i);
    int m, d, p;
    m = (mode == 3) ? 0 : mode;
    if (m == 2) return 8'(value & 255);
    if (m == 0) begin
      d = (value >> (4 * (3 - i))) & 15;
      return (d < 10) ? 8'(48 + d) : 8'(65 + d - 10);
    end
    p = 1;
    for (int k = 0; k < 4 - i; k++) p = p * 10;
    d = (value / p) % 10;
    if (i < 4 && value < p) return 8'h20;
    return 8'(48 + d);
  endfunction

  task automatic run_req(input string tag, input int mode, input int row, input int col,
                         input int value, input bit hold);
    int n, start, cyc, i;
    bit ev, ed, er;
    logic [11:0] ea;
    logic [7:0]  ec;
    n     = (mode == 1) ? 5 : (mode == 2) ? 1 : 4;
    start = (mode == 1) ? 17 : 1;
    cyc   = 0;
    while (req_ready !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_wait got %b want 1", tag, req_ready);
      return;
    end
    req_valid = 1'b1;
    req_mode  = 2'(mode);
    req_row   = 6'(row);
    req_col   = 6'(col);
    req_value = 16'(value);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    req_mode  = 2'($urandom);
    req_row   = 6'($urandom);
    req_col   = 6'($urandom);
    req_value = 16'($urandom);
    for (int c = 1; c <= start + n + 1; c++) begin
      i  = c - start;
      ev = (c >= start) && (c < start + n);
      ed = (c == start + n);
      er = (c == start + n + 1);
      total++;
      if (w_valid !== ev) begin
        bad++;
        $display("FAIL %s w_valid c%0d got %b want %b", tag, c, w_valid, ev);
      end
      if (ev) begin
        ea = 12'(row * 64 + (col + i) % 64);
        ec = exp_char(mode, value, i);
        total++;
        if (w_addr !== ea) begin
          bad++;
          $display("FAIL %s w_addr c%0d got %h want %h", tag, c, w_addr, ea);
        end
        total++;
        if (w_data !== ec) begin
          bad++;
          $display("FAIL %s w_data c%0d got %h want %h", tag, c, w_data, ec);
        end
      end
      total++;
      if (done !== ed) begin
        bad++;
        $display("FAIL %s done c%0d got %b want %b", tag, c, done, ed);
      end
      total++;
      if (req_ready !== er || busy !== ~er) begin
        bad++;
        $display("FAIL %s ready c%0d got %b/%b want %b", tag, c, req_ready, busy, er);
      end
      if (c < start + n + 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag, input bit want_ready);
    total++;
    if (w_valid !== 1'b0 || done !== 1'b0 || w_addr !== 12'h000 || w_data !== 8'h00) begin
      bad++;
      $display("FAIL %s outputs got v=%b d=%b a=%h w=%h want all 0", tag, w_valid, done,
               w_addr, w_data);
    end
    total++;
    if (req_ready !== want_ready) begin
      bad++;
      $display("FAIL %s req_ready got %b want %b", tag, req_ready, want_ready);
    end
  endtask

  task automatic test_reset();
    #12;
    check_idle_outputs("reset_hold", 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_busy got %b want 1", busy);
    end
    video_reset_done = 1'b1;
    #1;
    check_idle_outputs("reset_vrd", 1'b0);
    @(posedge clk); #1;
    reset_p = 1'b0;
    #1;
    check_idle_outputs("reset_release", 1'b1);
  endtask

  task automatic test_hex();
    run_req("hex_beef", 0, 16, 2, 16'hBEEF, 1'b0);
    run_req("hex_0000", 0, 40, 20, 16'h0000, 1'b0);
  endtask

  task automatic test_decimal();
    run_req("dec_1234", 1, 0, 0, 1234, 1'b0);
    run_req("dec_0", 1, 0, 0, 0, 1'b0);
    run_req("dec_65535", 1, 0, 0, 65535, 1'b0);
    run_req("dec_10000", 1, 9, 30, 10000, 1'b0);
    run_req("dec_7", 1, 9, 60, 7, 1'b0);
  endtask

  task automatic test_wrap();
    run_req("wrap_hex", 0, 1, 62, 16'h0A5F, 1'b0);
  endtask

  task automatic test_char_mode3();
    run_req("char", 2, 63, 63, 16'h1248, 1'b0);
    run_req("mode3", 3, 0, 0, 16'h00FF, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      run_req("random", int'($urandom_range(3, 0)), int'($urandom_range(63, 0)),
              int'($urandom_range(63, 0)), int'($urandom_range(65535, 0)), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    run_req("b2b_first", 0, 2, 5, 16'h1F2E, 1'b1);
    run_req("b2b_second", 1, 2, 5, 40960, 1'b1);
    run_req("b2b_third", 2, 2, 5, 16'h0041, 1'b0);
  endtask

  task automatic test_gate_abort();
    video_reset_done = 1'b0;
    req_valid = 1'b1;
    req_mode  = 2'd0;
    req_row   = 6'd5;
    req_col   = 6'd10;
    req_value = 16'h1234;
    repeat (4) begin
      @(posedge clk); #1;
      check_idle_outputs("gate_low", 1'b0);
    end
    video_reset_done = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL gate_raise req_ready got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++;
    if (w_valid !== 1'b1 || w_addr !== 12'h14A || w_data !== 8'h31) begin
      bad++;
      $display("FAIL gate_c1 got v=%b a=%h d=%h want 1/14a/31", w_valid, w_addr, w_data);
    end
    @(posedge clk); #1;
    total++;
    if (w_valid !== 1'b1 || w_addr !== 12'h14B || w_data !== 8'h32) begin
      bad++;
      $display("FAIL gate_c2 got v=%b a=%h d=%h want 1/14b/32", w_valid, w_addr, w_data);
    end
    video_reset_done = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check_idle_outputs("abort", 1'b0);
    end
    video_reset_done = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_recover req_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_async_reset();
    req_valid = 1'b1;
    req_mode  = 2'd0;
    req_row   = 6'd3;
    req_col   = 6'd7;
    req_value = 16'hC0DE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (w_valid !== 1'b1 || w_data !== 8'h30) begin
      bad++;
      $display("FAIL arst_pre got v=%b d=%h want 1/30", w_valid, w_data);
    end
    #2;
    reset_p = 1'b1;
    #1;
    check_idle_outputs("arst_immediate", 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
      check_idle_outputs("arst_hold", 1'b0);
    end
    reset_p = 1'b0;
    #1;
    run_req("arst_after", 0, 3, 7, 16'h5A17, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_p          = 1'b1;
    video_reset_done = 1'b0;
    req_valid        = 1'b0;
    req_mode         = '0;
    req_row          = '0;
    req_col          = '0;
    req_value        = '0;
    test_reset();
    test_hex();
    test_decimal();
    test_wrap();
    test_char_mode3();
    test_gate_abort();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
